// File: rtl/uart_prog_loader_pkg.sv
// Shared types and constants for the UART program loader.
// Optional build macro: UPG_CHECKSUM_EN adds the trailing XOR checksum state.
package uart_prog_loader_pkg;

  localparam int unsigned UPG_ADDR_W          = 14;
  localparam int unsigned UPG_DATA_W          = 32;
  localparam int unsigned UPG_LEN_W           = 16;
  localparam int unsigned UART_CLKS_PER_BIT   = 87;
  localparam int unsigned UART_TIMEOUT_CYCLES = 1_000_000;
  localparam int unsigned UPG_MAX_WORDS       = 4096;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
`ifdef UPG_CHECKSUM_EN
    ST_CHK    = 3'd5,
`endif
    ST_DONE   = 3'd6,
    ST_ERR    = 3'd7
  } upg_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_prog_loader_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling, start-glitch rejection.
module uart_rx_byte
  import uart_prog_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       valid_o,
  output logic       frame_err_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned HALF  = (CLKS_PER_BIT - 1) / 2;

  logic             rx_meta, rx_sync, rx_prev;
  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_d, ferr_d;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start edge.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      valid_o     <= valid_d;
      frame_err_o <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (rx_prev && !rx_sync) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == CNT_W'(HALF)) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          shift_d = {rx_sync, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          valid_d = rx_sync;
          ferr_d  = !rx_sync;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_o = shift_q;

endmodule

// File: rtl/uart_prog_loader.sv
// Receives a length-prefixed program image over UART and drives the fetch-stage UPG write port.
// Optional build macro: UPG_CHECKSUM_EN (trailing XOR checksum byte over the data bytes).
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT   = UART_CLKS_PER_BIT,
  parameter int unsigned TIMEOUT_CYCLES = UART_TIMEOUT_CYCLES,
  parameter int unsigned MAX_WORDS      = UPG_MAX_WORDS
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  rx_i,
  output logic                  upg_wen_o,
  output logic [UPG_ADDR_W-1:0] upg_addr_o,
  output logic [UPG_DATA_W-1:0] upg_data_o,
  output logic                  upg_done_o,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

`ifdef UPG_CHECKSUM_EN
  localparam upg_state_t ST_FINAL = ST_CHK;
`else
  localparam upg_state_t ST_FINAL = ST_DONE;
`endif

  logic [7:0] rx_byte;
  logic       rx_valid, rx_ferr;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .rx_i        (rx_i),
    .byte_o      (rx_byte),
    .valid_o     (rx_valid),
    .frame_err_o (rx_ferr)
  );

  upg_state_t            state_q, state_d;
  logic [UPG_ADDR_W-1:0] addr_q, addr_d;
  logic [UPG_DATA_W-1:0] data_q, data_d;
  logic [1:0]            idx_q, idx_d;
  logic [UPG_LEN_W-1:0]  left_q, left_d;
  logic [7:0]            len_lo_q, len_lo_d;
  logic [TO_W-1:0]       to_q, to_d;
  logic [UPG_LEN_W-1:0]  len_c;
  logic                  rcv_c;
  logic                  wen_d, done_d, busy_d, err_d;
`ifdef UPG_CHECKSUM_EN
  logic [7:0]            chk_q, chk_d;
`endif

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      idx_q      <= '0;
      left_q     <= '0;
      len_lo_q   <= '0;
      to_q       <= '0;
      upg_wen_o  <= 1'b0;
      upg_done_o <= 1'b0;
      busy_o     <= 1'b0;
      err_o      <= 1'b0;
`ifdef UPG_CHECKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
      left_q     <= left_d;
      len_lo_q   <= len_lo_d;
      to_q       <= to_d;
      upg_wen_o  <= wen_d;
      upg_done_o <= done_d;
      busy_o     <= busy_d;
      err_o      <= err_d;
`ifdef UPG_CHECKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  // start_i outranks everything; framing error and timeout outrank byte decoding.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    idx_d    = idx_q;
    left_d   = left_q;
    len_lo_d = len_lo_q;
    to_d     = '0;
    wen_d    = 1'b0;
    len_c    = {rx_byte, len_lo_q};
    rcv_c    = !(state_q inside {ST_IDLE, ST_DONE, ST_ERR});
`ifdef UPG_CHECKSUM_EN
    chk_d    = chk_q;
`endif
    if (start_i) begin
      state_d = ST_LEN_LO;
      addr_d  = '0;
      data_d  = '0;
      idx_d   = '0;
`ifdef UPG_CHECKSUM_EN
      chk_d   = '0;
`endif
    end else if (rcv_c) begin
      to_d = rx_valid ? '0 : to_q + TO_W'(1);
      if (rx_ferr) begin
        state_d = ST_ERR;
      end else if (!rx_valid && to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        state_d = ST_ERR;
      end else begin
        case (state_q)
          ST_LEN_LO: begin
            if (rx_valid) begin
              len_lo_d = rx_byte;
              state_d  = ST_LEN_HI;
            end
          end
          ST_LEN_HI: begin
            if (rx_valid) begin
              idx_d  = '0;
              left_d = len_c;
              if (len_c > UPG_LEN_W'(MAX_WORDS)) state_d = ST_ERR;
              else if (len_c == '0)              state_d = ST_FINAL;
              else                               state_d = ST_DATA;
            end
          end
          ST_DATA: begin
            if (rx_valid) begin
              data_d = {rx_byte, data_q[UPG_DATA_W-1:8]};
              idx_d  = idx_q + 2'd1;
`ifdef UPG_CHECKSUM_EN
              chk_d  = chk_q ^ rx_byte;
`endif
              if (idx_q == 2'd3) begin
                state_d = ST_WRITE;
                wen_d   = 1'b1;
              end
            end
          end
          ST_WRITE: begin
            addr_d  = addr_q + UPG_ADDR_W'(4);
            left_d  = left_q - UPG_LEN_W'(1);
            state_d = (left_q == UPG_LEN_W'(1)) ? ST_FINAL : ST_DATA;
          end
`ifdef UPG_CHECKSUM_EN
          ST_CHK: begin
            if (rx_valid) state_d = (rx_byte == chk_q) ? ST_DONE : ST_ERR;
          end
`endif
          default: state_d = state_q;
        endcase
      end
    end
    done_d = (state_d == ST_DONE);
    err_d  = (state_d == ST_ERR);
    busy_d = !(state_d inside {ST_IDLE, ST_DONE, ST_ERR});
  end

  assign upg_addr_o = addr_q;
  assign upg_data_o = data_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed self-checking bench for uart_prog_loader; honours UPG_CHECKSUM_EN.
module tb_uart_prog_loader;

  localparam int unsigned CPB = 32;
  localparam int unsigned TO  = 2000;
  localparam int unsigned MW  = 4096;

  logic        clk_i   = 1'b0;
  logic        rst_n   = 1'b0;
  logic        start_i = 1'b0;
  logic        rx_i    = 1'b1;
  logic        upg_wen_o;
  logic [13:0] upg_addr_o;
  logic [31:0] upg_data_o;
  logic        upg_done_o, busy_o, err_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [13:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int run = 0;
  int max_run = 0;
  int base;

  always #5 clk_i = ~clk_i;

  uart_prog_loader #(
    .CLKS_PER_BIT   (CPB),
    .TIMEOUT_CYCLES (TO),
    .MAX_WORDS      (MW)
  ) dut (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .rx_i       (rx_i),
    .upg_wen_o  (upg_wen_o),
    .upg_addr_o (upg_addr_o),
    .upg_data_o (upg_data_o),
    .upg_done_o (upg_done_o),
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

  // Write-port monitor, sampled on the falling edge.
  always @(negedge clk_i) begin
    if (upg_wen_o) begin
      wr_addr.push_back(upg_addr_o);
      wr_data.push_back(upg_data_o);
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk_i);
    rx_i = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      idle(CPB);
    end
    rx_i = stop_bit;
    idle(CPB);
    rx_i = 1'b1;
  endtask

  task automatic send_len(input logic [15:0] n);
    send_byte(n[7:0], 1'b1);
    send_byte(n[15:8], 1'b1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic pulse_start();
    @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic send_chk(input logic [7:0] c);
`ifdef UPG_CHECKSUM_EN
    send_byte(c, 1'b1);
`else
    if (c == 8'hxx) idle(1);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    check("rst_wen",  32'(upg_wen_o),  32'd0);
    check("rst_addr", 32'(upg_addr_o), 32'd0);
    check("rst_data", upg_data_o,      32'd0);
    check("rst_done", 32'(upg_done_o), 32'd0);
    check("rst_busy", 32'(busy_o),     32'd0);
    check("rst_err",  32'(err_o),      32'd0);
    rst_n = 1'b1;
    idle(5);

    // Nominal two-word frame
    base = wr_addr.size();
    pulse_start();
    send_len(16'd2);
    check("nom_busy", 32'(busy_o), 32'd1);
    send_word(32'h0050_0093);
    send_word(32'h00A0_0113);
    send_chk(8'h71);
    idle(4);
    check("nom_nwr", 32'(wr_addr.size() - base), 32'd2);
    if (wr_addr.size() >= base + 2) begin
      check("nom_a0", 32'(wr_addr[base]),   32'h0000);
      check("nom_d0", wr_data[base],        32'h0050_0093);
      check("nom_a1", 32'(wr_addr[base+1]), 32'h0004);
      check("nom_d1", wr_data[base+1],      32'h00A0_0113);
    end
    check("nom_done", 32'(upg_done_o), 32'd1);
    check("nom_busy_end", 32'(busy_o), 32'd0);
    check("nom_err", 32'(err_o), 32'd0);

    // Reset after 3 data bytes, then a clean reload
    base = wr_addr.size();
    pulse_start();
    send_len(16'd1);
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h34, 1'b1);
    @(negedge clk_i);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy_o),     32'd0);
    check("mid_rst_done", 32'(upg_done_o), 32'd0);
    check("mid_rst_addr", 32'(upg_addr_o), 32'd0);
    check("mid_rst_data", upg_data_o,      32'd0);
    idle(3);
    rst_n = 1'b1;
    idle(3);
    check("mid_rst_nwr", 32'(wr_addr.size() - base), 32'd0);
    pulse_start();
    send_len(16'd1);
    send_word(32'h1234_5678);
    send_chk(8'h08);
    idle(4);
    check("reload_nwr", 32'(wr_addr.size() - base), 32'd1);
    if (wr_addr.size() >= base + 1) begin
      check("reload_a0", 32'(wr_addr[base]), 32'h0000);
      check("reload_d0", wr_data[base],      32'h1234_5678);
    end
    check("reload_done", 32'(upg_done_o), 32'd1);

    // Empty image
    base = wr_addr.size();
    pulse_start();
    check("empty_done_clr", 32'(upg_done_o), 32'd0);
    send_len(16'd0);
    send_chk(8'h00);
    idle(4);
    check("empty_done", 32'(upg_done_o), 32'd1);
    check("empty_nwr", 32'(wr_addr.size() - base), 32'd0);

    // Oversize length 4097
    base = wr_addr.size();
    pulse_start();
    send_len(16'd4097);
    idle(4);
    check("big_err",  32'(err_o),      32'd1);
    check("big_done", 32'(upg_done_o), 32'd0);
    check("big_nwr",  32'(wr_addr.size() - base), 32'd0);

    // Inter-byte timeout after 5 data bytes
    base = wr_addr.size();
    pulse_start();
    check("to_err_clr", 32'(err_o), 32'd0);
    send_len(16'd2);
    send_word(32'hCAFE_F00D);
    send_byte(8'h11, 1'b1);
    check("to_err_early", 32'(err_o), 32'd0);
    idle(TO + 50);
    check("to_err", 32'(err_o), 32'd1);
    check("to_nwr", 32'(wr_addr.size() - base), 32'd1);
    if (wr_addr.size() >= base + 1) check("to_a0", 32'(wr_addr[base]), 32'h0000);
    pulse_start();
    idle(1);
    check("to_restart_err", 32'(err_o), 32'd0);
    check("to_restart_busy", 32'(busy_o), 32'd1);

    // Framing error
    pulse_start();
    send_byte(8'h01, 1'b0);
    idle(CPB);
    check("ferr_err", 32'(err_o), 32'd1);

    // Start-bit glitch ignored in LEN_LO
    base = wr_addr.size();
    pulse_start();
    rx_i = 1'b0;
    idle(10);
    rx_i = 1'b1;
    idle(2 * 10 * CPB);
    check("glitch_busy", 32'(busy_o), 32'd1);
    send_len(16'd1);
    send_word(32'hDEAD_BEEF);
    send_chk(8'h22);
    idle(4);
    check("glitch_done", 32'(upg_done_o), 32'd1);
    check("glitch_nwr", 32'(wr_addr.size() - base), 32'd1);
    if (wr_addr.size() >= base + 1) check("glitch_d0", wr_data[base], 32'hDEAD_BEEF);

`ifdef UPG_CHECKSUM_EN
    // Checksum mismatch
    pulse_start();
    send_len(16'd1);
    send_word(32'h1234_5678);
    send_byte(8'h09, 1'b1);
    idle(4);
    check("chk_bad_err",  32'(err_o),      32'd1);
    check("chk_bad_done", 32'(upg_done_o), 32'd0);
`endif

    check("wen_width", 32'(max_run), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
